alu_wb_buffer: RTL and testbench

Writeback-side receiver for the simple ALU lane: captures each writeback packet the ALU produces, drives the physical register file write port and the bypass network one cycle later, and queues the active-list completion in a small FIFO. The active-list completion port is shared and may stall, so completions drain under a valid/ready handshake. The block sits between the simple ALU output and the register file, bypass network and active list, and honours recovery flushes.

---
 rtl/alu_wb_buffer.sv | 128 ++++++++++++
 tb/tb_alu_wb_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - ALU writeback stage register plus active-list completion FIFO
`timescale 1ns/1ps
module alu_wb_buffer #(
  parameter int DATA_W = 64,
  parameter int PHY_W  = 7,
  parameter int AL_W   = 7,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     wbValid_i,
  input  logic [PHY_W-1:0]         wbPhyDest_i,
  input  logic [DATA_W-1:0]        wbDestData_i,
  input  logic                     wbDestValid_i,
  input  logic                     wbExecuted_i,
  input  logic [AL_W-1:0]          wbAlID_i,
  output logic                     wbReady_o,
  output logic                     rfWrEn_o,
  output logic [PHY_W-1:0]         rfWrAddr_o,
  output logic [DATA_W-1:0]        rfWrData_o,
  output logic                     bypassValid_o,
  output logic [PHY_W-1:0]         bypassTag_o,
  output logic [DATA_W-1:0]        bypassData_o,
  output logic                     ctrlValid_o,
  output logic [AL_W-1:0]          ctrlAlID_o,
  output logic                     ctrlExecuted_o,
  input  logic                     ctrlReady_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              stg_valid_q, stg_valid_d;
  logic              stg_dest_valid_q, stg_dest_valid_d;
  logic [PHY_W-1:0]  stg_phy_q, stg_phy_d;
  logic [DATA_W-1:0] stg_data_q, stg_data_d;
  logic              overflow_q, overflow_d;
  logic [AL_W:0]     mem_q [DEPTH];
  logic [AL_W:0]     mem_d [DEPTH];

  logic accept;
  logic pop;

  assign wbReady_o      = (count_q < CNT_W'(DEPTH));
  assign ctrlValid_o    = (count_q != '0);
  assign accept         = wbValid_i & wbReady_o & ~flush_i;
  assign pop            = ctrlValid_o & ctrlReady_i & ~flush_i;

  assign rfWrEn_o       = stg_valid_q & stg_dest_valid_q;
  assign rfWrAddr_o     = stg_phy_q;
  assign rfWrData_o     = stg_data_q;
  assign bypassValid_o  = rfWrEn_o;
  assign bypassTag_o    = stg_phy_q;
  assign bypassData_o   = stg_data_q;
  assign ctrlAlID_o     = mem_q[rd_ptr_q][AL_W:1];
  assign ctrlExecuted_o = mem_q[rd_ptr_q][0];
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;

  always_comb begin
    count_d          = count_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    stg_valid_d      = 1'b0;
    stg_dest_valid_d = stg_dest_valid_q;
    stg_phy_d        = stg_phy_q;
    stg_data_d       = stg_data_q;
    overflow_d       = overflow_q;
    mem_d            = mem_q;
    // Flush wins over accept, pop and the overflow check alike.
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      overflow_d = overflow_q | (wbValid_i & ~wbReady_o);
      if (accept) begin
        stg_valid_d      = 1'b1;
        stg_dest_valid_d = wbDestValid_i;
        stg_phy_d        = wbPhyDest_i;
        stg_data_d       = wbDestData_i;
        mem_d[wr_ptr_q]  = {wbAlID_i, wbExecuted_i};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      stg_valid_q      <= 1'b0;
      stg_dest_valid_q <= 1'b0;
      stg_phy_q        <= '0;
      stg_data_q       <= '0;
      overflow_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      stg_valid_q      <= stg_valid_d;
      stg_dest_valid_q <= stg_dest_valid_d;
      stg_phy_q        <= stg_phy_d;
      stg_data_q       <= stg_data_d;
      overflow_q       <= overflow_d;
      mem_q            <= mem_d;
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - directed scoreboard bench for alu_wb_buffer
`timescale 1ns/1ps
module tb_alu_wb_buffer;

  localparam int DATA_W = 64;
  localparam int PHY_W  = 7;
  localparam int AL_W   = 7;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              flush_i;
  logic              wbValid_i;
  logic [PHY_W-1:0]  wbPhyDest_i;
  logic [DATA_W-1:0] wbDestData_i;
  logic              wbDestValid_i;
  logic              wbExecuted_i;
  logic [AL_W-1:0]   wbAlID_i;
  logic              wbReady_o;
  logic              rfWrEn_o;
  logic [PHY_W-1:0]  rfWrAddr_o;
  logic [DATA_W-1:0] rfWrData_o;
  logic              bypassValid_o;
  logic [PHY_W-1:0]  bypassTag_o;
  logic [DATA_W-1:0] bypassData_o;
  logic              ctrlValid_o;
  logic [AL_W-1:0]   ctrlAlID_o;
  logic              ctrlExecuted_o;
  logic              ctrlReady_i;
  logic [$clog2(DEPTH):0] count_o;
  logic              overflow_o;

  alu_wb_buffer #(.DATA_W(DATA_W), .PHY_W(PHY_W), .AL_W(AL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .wbValid_i(wbValid_i), .wbPhyDest_i(wbPhyDest_i), .wbDestData_i(wbDestData_i),
    .wbDestValid_i(wbDestValid_i), .wbExecuted_i(wbExecuted_i), .wbAlID_i(wbAlID_i),
    .wbReady_o(wbReady_o),
    .rfWrEn_o(rfWrEn_o), .rfWrAddr_o(rfWrAddr_o), .rfWrData_o(rfWrData_o),
    .bypassValid_o(bypassValid_o), .bypassTag_o(bypassTag_o), .bypassData_o(bypassData_o),
    .ctrlValid_o(ctrlValid_o), .ctrlAlID_o(ctrlAlID_o), .ctrlExecuted_o(ctrlExecuted_o),
    .ctrlReady_i(ctrlReady_i), .count_o(count_o), .overflow_o(overflow_o)
  );

  int total = 0;
  int bad   = 0;

  logic [AL_W:0]     sb_q [$];
  int                drained [$];
  logic              m_ovf;
  logic              exp_en;
  logic [PHY_W-1:0]  exp_addr;
  logic [DATA_W-1:0] exp_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rf_en", 64'(rfWrEn_o), 64'(exp_en));
    chk("byp_valid", 64'(bypassValid_o), 64'(exp_en));
    if (exp_en) begin
      chk("rf_addr", 64'(rfWrAddr_o), 64'(exp_addr));
      chk("rf_data", rfWrData_o, exp_data);
      chk("byp_tag", 64'(bypassTag_o), 64'(exp_addr));
      chk("byp_data", bypassData_o, exp_data);
    end
    chk("ctrl_valid", 64'(ctrlValid_o), 64'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      chk("ctrl_alid", 64'(ctrlAlID_o), 64'(sb_q[0][AL_W:1]));
      chk("ctrl_exec", 64'(ctrlExecuted_o), 64'(sb_q[0][0]));
    end
    chk("count", 64'(count_o), 64'(sb_q.size()));
    chk("wb_ready", 64'(wbReady_o), 64'(sb_q.size() < DEPTH));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  // Predict the edge from the inputs currently driven, then advance and compare.
  task automatic cycle();
    logic full, acc, pop;
    full = (sb_q.size() == DEPTH);
    acc  = wbValid_i && !full && !flush_i;
    pop  = (sb_q.size() != 0) && ctrlReady_i && !flush_i;
    @(posedge clk);
    #1;
    if (flush_i) begin
      sb_q.delete();
      exp_en = 1'b0;
    end else begin
      if (wbValid_i && full) m_ovf = 1'b1;
      if (pop) begin
        drained.push_back(int'(sb_q[0][AL_W:1]));
        void'(sb_q.pop_front());
      end
      exp_en = acc && wbDestValid_i;
      if (acc) begin
        exp_addr = wbPhyDest_i;
        exp_data = wbDestData_i;
        sb_q.push_back({wbAlID_i, wbExecuted_i});
      end
    end
    check_outputs();
  endtask

  task automatic send(input int al, input int phy, input logic [63:0] data, input logic dv, input logic rdy);
    wbValid_i     = 1'b1;
    wbAlID_i      = AL_W'(al);
    wbPhyDest_i   = PHY_W'(phy);
    wbDestData_i  = data;
    wbDestValid_i = dv;
    wbExecuted_i  = al[0];
    ctrlReady_i   = rdy;
    cycle();
    wbValid_i     = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    wbValid_i   = 1'b0;
    ctrlReady_i = rdy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_drain(input string tag, input int first, input int n);
    chk({tag, "_n"}, 64'(drained.size()), 64'(n));
    for (int i = 0; i < n && i < drained.size(); i++)
      chk({tag, "_order"}, 64'(drained[i]), 64'(first + i));
    drained.delete();
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; wbValid_i = 1'b0; wbPhyDest_i = '0; wbDestData_i = '0;
    wbDestValid_i = 1'b0; wbExecuted_i = 1'b0; wbAlID_i = '0; ctrlReady_i = 1'b0;
    m_ovf = 1'b0; exp_en = 1'b0; exp_addr = '0; exp_data = '0;
    #12;
    check_outputs();
    chk("rst_addr", 64'(rfWrAddr_o), 64'd0);
    chk("rst_data", rfWrData_o, 64'd0);
    chk("rst_alid", 64'(ctrlAlID_o), 64'd0);
    chk("rst_exec", 64'(ctrlExecuted_o), 64'd0);
    #5 reset = 1'b0;

    // Single op
    send(9, 5, 64'h1234, 1'b1, 1'b1);
    chk("single_rf_en", 64'(rfWrEn_o), 64'd1);
    chk("single_addr", 64'(rfWrAddr_o), 64'd5);
    chk("single_data", rfWrData_o, 64'h1234);
    chk("single_ctrl_alid", 64'(ctrlAlID_o), 64'd9);
    idle(1, 1'b1);
    chk("single_count_t2", 64'(count_o), 64'd0);
    drained.delete();

    // destValid = 0
    send(12, 6, 64'hdead, 1'b0, 1'b1);
    chk("nodest_rf_en", 64'(rfWrEn_o), 64'd0);
    chk("nodest_byp", 64'(bypassValid_o), 64'd0);
    chk("nodest_ctrl_v", 64'(ctrlValid_o), 64'd1);
    chk("nodest_alid", 64'(ctrlAlID_o), 64'd12);
    idle(2, 1'b1);
    drained.delete();

    // Backpressure, overflow, wrap
    for (int i = 1; i <= 4; i++) send(i, i + 16, 64'(i) * 64'h1111, 1'b1, 1'b0);
    chk("bp_count", 64'(count_o), 64'd4);
    chk("bp_ready", 64'(wbReady_o), 64'd0);
    send(5, 21, 64'h5555, 1'b1, 1'b0);
    chk("bp_overflow", 64'(overflow_o), 64'd1);
    idle(4, 1'b1);
    chk_drain("bp_drain", 1, 4);
    for (int i = 10; i < 16; i++) send(i, i, 64'hA000 + 64'(i), 1'b1, 1'b1);
    idle(2, 1'b1);
    chk_drain("wrap_drain", 10, 6);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // Simultaneous push/pop at count 2
    send(20, 1, 64'h20, 1'b1, 1'b0);
    send(21, 2, 64'h21, 1'b1, 1'b0);
    for (int i = 22; i <= 24; i++) begin
      send(i, i, 64'(i), 1'b1, 1'b1);
      chk("pp_count", 64'(count_o), 64'd2);
    end
    idle(3, 1'b1);
    chk_drain("pp_drain", 20, 5);

    // Flush with 3 queued and a packet inbound
    for (int i = 30; i < 33; i++) send(i, i, 64'(i), 1'b1, 1'b0);
    flush_i = 1'b1;
    send(33, 33, 64'hBAD, 1'b1, 1'b1);
    flush_i = 1'b0;
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_ctrl_v", 64'(ctrlValid_o), 64'd0);
    chk("flush_rf_en", 64'(rfWrEn_o), 64'd0);
    idle(4, 1'b1);
    chk_drain("flush_drain", 0, 0);

    // Async reset mid-drain
    for (int i = 40; i < 43; i++) send(i, i, 64'(i), 1'b1, 1'b0);
    idle(1, 1'b1);
    #3 reset = 1'b1;
    #1;
    sb_q.delete(); m_ovf = 1'b0; exp_en = 1'b0;
    check_outputs();
    chk("arst_ready", 64'(wbReady_o), 64'd1);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    chk("arst_alid", 64'(ctrlAlID_o), 64'd0);
    @(negedge clk) reset = 1'b0;
    drained.delete();
    idle(1, 1'b1);
    send(50, 3, 64'hCAFE, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk_drain("post_rst", 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
